// File: rtl/hififo_pkg.sv
// Shared constants and helpers for the from-PC FIFO read-request path:
// TLP header fields, block size, tag layout and read-request FSM states.
package hififo_pkg;

    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
    localparam logic [4:0] TYPE_MEM       = 5'b00000;

    localparam int BLOCK_BYTES = 512;
    localparam int IDX_W       = 3;

    typedef enum logic [1:0] {
        IDLE,
        HDR0,
        HDR1
    } rdReqState_e;

    // Completion path and FIFO decode the tag as channel[7:3], block[2:0].
    function automatic logic [7:0] makeTag(input logic [4:0] chan, input logic [2:0] blk);
        return {chan, blk};
    endfunction

endpackage

// File: rtl/hififo_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant and index from the request
// vector, starting the search at a registered pointer that advances past each winner.
module hififo_rr_arbiter
    import hififo_pkg::*;
#(
    parameter int NCH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NCH-1:0]   req_i,
    input  logic             advance_i,
    input  logic [IDX_W-1:0] lastIdx_i,
    output logic [NCH-1:0]   grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    localparam logic [IDX_W:0] NCH_V = (IDX_W + 1)'(NCH);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W:0]   bestDist;

    // Distance from the pointer to channel c going forward around the ring.
    function automatic logic [IDX_W:0] ringDist(input logic [IDX_W:0] c, input logic [IDX_W:0] p);
        if (c >= p) begin
            return c - p;
        end
        return c + NCH_V - p;
    endfunction

    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        bestDist = NCH_V;
        for (int c = 0; c < NCH; c++) begin
            if (req_i[c] && (ringDist((IDX_W + 1)'(c), {1'b0, ptr_q}) < bestDist)) begin
                bestDist   = ringDist((IDX_W + 1)'(c), {1'b0, ptr_q});
                grant_o    = '0;
                grant_o[c] = 1'b1;
                idx_o      = IDX_W'(c);
            end
        end
    end

    assign any_o = |req_i;

    always_comb begin
        ptr_d = (lastIdx_i == IDX_W'(NCH - 1)) ? '0 : lastIdx_i + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hififo_read_request.sv
// Per-channel read-request issuer: arbitrates channels round-robin and emits
// 2-beat PCIe MRd TLPs. Define HIFIFO_RDREQ_FORCE_4DW_EN to always use 4DW headers.
module hififo_read_request
    import hififo_pkg::*;
#(
    parameter int NCH      = 8,
    parameter int BLOCK_DW = 128
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      requester_id,
    input  logic [NCH-1:0]   req_valid,
    output logic [NCH-1:0]   req_ready,
    input  logic             addr_write,
    input  logic [2:0]       addr_channel,
    input  logic [63:0]      addr_data,
    input  logic [NCH-1:0]   chan_enable,
    output logic             tlp_valid,
    input  logic             tlp_ready,
    output logic [63:0]      tlp_data,
    output logic             tlp_last
);

    localparam logic [9:0]  LEN_DW    = 10'(BLOCK_DW);
    localparam logic [63:0] ADDR_STEP = 64'(BLOCK_BYTES);

    rdReqState_e state_q, state_d;

    logic [63:0]      addr_q [NCH];
    logic [2:0]       blk_q  [NCH];
    logic [IDX_W-1:0] chan_q;
    logic [63:0]      addrLat_q;
    logic [7:0]       tag_q;
    logic             is4dw_q;
    logic [NCH-1:0]   req_ready_q;
    logic [NCH-1:0]   readyNext;

    logic [NCH-1:0]   eligible;
    logic [NCH-1:0]   grant;
    logic [IDX_W-1:0] grantIdx;
    logic             anyGrant;
    logic             grantTake;
    logic             hdr1Accept;
    logic [63:0]      selAddr;
    logic [2:0]       selBlk;
    logic             wantFour;
    logic [31:0]      dw0;
    logic [31:0]      dw1;

    // A channel whose strobe is on the wire this cycle is not yet re-grantable.
    assign eligible = req_valid & chan_enable & ~req_ready_q;

    hififo_rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req_i     (eligible),
        .advance_i (hdr1Accept),
        .lastIdx_i (chan_q),
        .grant_o   (grant),
        .idx_o     (grantIdx),
        .any_o     (anyGrant)
    );

    always_comb begin
        selAddr = '0;
        selBlk  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (grant[c]) begin
                selAddr |= addr_q[c];
                selBlk  |= blk_q[c];
            end
        end
    end

`ifdef HIFIFO_RDREQ_FORCE_4DW_EN
    assign wantFour = 1'b1;
`else
    assign wantFour = (selAddr[63:32] != 32'h0);
`endif

    always_comb begin
        dw0 = {(is4dw_q ? FMT_4DW_NODATA : FMT_3DW_NODATA), TYPE_MEM, 14'h0, LEN_DW};
        dw1 = {requester_id, tag_q, 4'hF, 4'hF};
    end

    always_comb begin
        state_d    = state_q;
        tlp_valid  = 1'b0;
        tlp_last   = 1'b0;
        tlp_data   = '0;
        grantTake  = 1'b0;
        hdr1Accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (anyGrant) begin
                    grantTake = 1'b1;
                    state_d   = HDR0;
                end
            end
            HDR0: begin
                tlp_valid = 1'b1;
                tlp_data  = {dw1, dw0};
                if (tlp_ready) begin
                    state_d = HDR1;
                end
            end
            HDR1: begin
                tlp_valid = 1'b1;
                tlp_last  = 1'b1;
                tlp_data  = is4dw_q ? {addrLat_q[31:0], addrLat_q[63:32]}
                                    : {32'h0, addrLat_q[31:0]};
                if (tlp_ready) begin
                    hdr1Accept = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        readyNext = '0;
        if (hdr1Accept) begin
            readyNext[chan_q] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            chan_q      <= '0;
            addrLat_q   <= '0;
            tag_q       <= '0;
            is4dw_q     <= 1'b0;
            req_ready_q <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= readyNext;
            if (grantTake) begin
                chan_q    <= grantIdx;
                addrLat_q <= selAddr;
                tag_q     <= makeTag({2'b00, grantIdx}, selBlk);
                is4dw_q   <= wantFour;
            end
        end
    end

    // A host address write beats the post-request increment on the same channel.
    always_ff @(posedge clock) begin
        for (int c = 0; c < NCH; c++) begin
            if (reset) begin
                addr_q[c] <= '0;
                blk_q[c]  <= '0;
            end else begin
                if (addr_write && (addr_channel == IDX_W'(c))) begin
                    addr_q[c] <= addr_data & ~64'h1FF;
                end else if (hdr1Accept && (chan_q == IDX_W'(c))) begin
                    addr_q[c] <= addr_q[c] + ADDR_STEP;
                end
                if (hdr1Accept && (chan_q == IDX_W'(c))) begin
                    blk_q[c] <= blk_q[c] + 3'd1;
                end
            end
        end
    end

    assign req_ready = req_ready_q;

endmodule

// File: tb/tb_hififo_read_request.sv
// Self-checking bench for hififo_read_request: transaction-level reference model
// checked every cycle, plus directed literal expectations and randomized traffic.
module tb_hififo_read_request;

    localparam int NCH      = 8;
    localparam int BLOCK_DW = 128;

`ifdef HIFIFO_RDREQ_FORCE_4DW_EN
    localparam bit FORCE4 = 1'b1;
`else
    localparam bit FORCE4 = 1'b0;
`endif

    logic           clock        = 1'b0;
    logic           reset        = 1'b1;
    logic [15:0]    requester_id = '0;
    logic [NCH-1:0] req_valid    = '0;
    logic [NCH-1:0] req_ready;
    logic           addr_write   = 1'b0;
    logic [2:0]     addr_channel = '0;
    logic [63:0]    addr_data    = '0;
    logic [NCH-1:0] chan_enable  = '0;
    logic           tlp_valid;
    logic           tlp_ready    = 1'b0;
    logic [63:0]    tlp_data;
    logic           tlp_last;

    int checks = 0;
    int errors = 0;

    hififo_read_request #(
        .NCH      (NCH),
        .BLOCK_DW (BLOCK_DW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .requester_id (requester_id),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .addr_write   (addr_write),
        .addr_channel (addr_channel),
        .addr_data    (addr_data),
        .chan_enable  (chan_enable),
        .tlp_valid    (tlp_valid),
        .tlp_ready    (tlp_ready),
        .tlp_data     (tlp_data),
        .tlp_last     (tlp_last)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Reference model: per-channel address/block, RR pointer, and the beats of
    // the TLP currently on the wire, all advanced once per clock at the negedge.
    logic [63:0]    mAddr [NCH];
    int             mBlk  [NCH];
    int             mPtr      = 0;
    logic [NCH-1:0] mReady    = '0;
    bit             mActive   = 1'b0;
    int             mBeat     = 0;
    int             mChan     = 0;
    logic [63:0]    mBeats [2];
    bit             mValid    = 1'b0;
    logic [NCH-1:0] mElig;
    logic [NCH-1:0] mNextReady;
    bit             mFound;
    bit             mFour;
    logic [63:0]    mA;
    logic [31:0]    mDw0;
    logic [31:0]    mDw1;
    logic [7:0]     mTag;

    always @(negedge clock) begin
        if (mValid) begin
            checkOutput("model_req_ready", 64'(req_ready), 64'(mReady));
            if (mActive) begin
                checkOutput("model_tlp_valid", 64'(tlp_valid), 64'd1);
                checkOutput("model_tlp_data", tlp_data, mBeats[mBeat]);
                checkOutput("model_tlp_last", 64'(tlp_last), (mBeat == 1) ? 64'd1 : 64'd0);
            end else begin
                checkOutput("model_tlp_valid", 64'(tlp_valid), 64'd0);
                checkOutput("model_tlp_last", 64'(tlp_last), 64'd0);
            end
        end
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                mAddr[c] = '0;
                mBlk[c]  = 0;
            end
            mPtr    = 0;
            mReady  = '0;
            mActive = 1'b0;
            mBeat   = 0;
            mValid  = 1'b1;
        end else if (mValid) begin
            mNextReady = '0;
            if (mActive) begin
                if (tlp_ready) begin
                    if (mBeat == 0) begin
                        mBeat = 1;
                    end else begin
                        mNextReady[mChan] = 1'b1;
                        mBlk[mChan]  = (mBlk[mChan] + 1) % 8;
                        mAddr[mChan] = mAddr[mChan] + 64'd512;
                        mPtr         = (mChan + 1) % NCH;
                        mActive      = 1'b0;
                    end
                end
            end else begin
                mElig  = req_valid & chan_enable & ~mReady;
                mFound = 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    if (!mFound && mElig[(mPtr + i) % NCH]) begin
                        mFound = 1'b1;
                        mChan  = (mPtr + i) % NCH;
                    end
                end
                if (mFound) begin
                    mA    = mAddr[mChan];
                    mFour = FORCE4 || (mA[63:32] != 32'h0);
                    mTag  = 8'(mChan * 8 + mBlk[mChan]);
                    mDw0  = (mFour ? 32'h2000_0000 : 32'h0) + 32'(BLOCK_DW);
                    mDw1  = {requester_id, mTag, 8'hFF};
                    mBeats[0] = {mDw1, mDw0};
                    mBeats[1] = mFour ? {mA[31:0], mA[63:32]} : {32'h0, mA[31:0]};
                    mActive = 1'b1;
                    mBeat   = 0;
                end
            end
            if (addr_write && (int'(addr_channel) < NCH)) begin
                mAddr[addr_channel] = addr_data & ~64'h1FF;
            end
            mReady = mNextReady;
        end
    end

    // Second header beat for an address whose upper 32 bits are zero.
    function automatic logic [63:0] hdr1Lo(input logic [31:0] lo);
        return FORCE4 ? {lo, 32'h0} : {32'h0, lo};
    endfunction

    localparam logic [31:0] DW0_LO = FORCE4 ? 32'h2000_0080 : 32'h0000_0080;

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic writeAddr(input int ch, input logic [63:0] a);
        addr_write   = 1'b1;
        addr_channel = 3'(ch);
        addr_data    = a;
        applyStimulus(1);
        addr_write   = 1'b0;
    endtask

    task automatic waitValid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (tlp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout actual=no_tlp_valid expected=tlp_valid", name);
        end
    endtask

    initial begin
        logic [7:0] tag;
        logic [63:0] held;
        int n3;
        int seqCh [3];
        seqCh[0] = 1;
        seqCh[1] = 3;
        seqCh[2] = 5;

        // Reset values
        reset     = 1'b1;
        tlp_ready = 1'b1;
        applyStimulus(3);
        @(negedge clock);
        checkOutput("reset_tlp_valid", 64'(tlp_valid), 64'd0);
        checkOutput("reset_tlp_last", 64'(tlp_last), 64'd0);
        checkOutput("reset_tlp_data", tlp_data, 64'd0);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        applyStimulus(1);
        reset        = 1'b0;
        requester_id = 16'h0100;
        chan_enable  = '1;

        // Channel 2, 3DW request
        writeAddr(2, 64'h0000_0000_1234_5000);
        req_valid = 8'h04;
        waitValid("t1_hdr0");
        checkOutput("t1_hdr0", tlp_data, {32'h0100_10FF, DW0_LO});
        checkOutput("t1_hdr0_last", 64'(tlp_last), 64'd0);
        applyStimulus(1);
        req_valid = '0;
        @(negedge clock);
        checkOutput("t1_hdr1", tlp_data, hdr1Lo(32'h1234_5000));
        checkOutput("t1_hdr1_last", 64'(tlp_last), 64'd1);
        checkOutput("t1_no_ready_yet", 64'(req_ready), 64'd0);
        @(negedge clock);
        checkOutput("t1_ready_pulse", 64'(req_ready), 64'h04);
        @(negedge clock);
        checkOutput("t1_ready_single", 64'(req_ready), 64'd0);
        applyStimulus(1);

        // Channel 0, 64-bit address forces 4DW
        writeAddr(0, 64'h0000_0001_8000_0000);
        req_valid = 8'h01;
        waitValid("t2_hdr0");
        checkOutput("t2_hdr0", tlp_data, 64'h0100_00FF_2000_0080);
        applyStimulus(1);
        req_valid = '0;
        @(negedge clock);
        checkOutput("t2_hdr1", tlp_data, 64'h8000_0000_0000_0001);
        applyStimulus(1);
        writeAddr(0, 64'h0000_0000_0000_1000);
        req_valid = 8'h01;
        waitValid("t2b_hdr0");
        checkOutput("t2b_hdr0", tlp_data, {32'h0100_01FF, DW0_LO});
        applyStimulus(1);
        req_valid = '0;
        @(negedge clock);
        checkOutput("t2b_hdr1", tlp_data, hdr1Lo(32'h0000_1000));
        applyStimulus(2);

        // Round robin across channels 1, 3, 5
        writeAddr(3, 64'h0000_0000_0004_0000);
        req_valid = 8'b0010_1010;
        n3 = 0;
        for (int k = 0; k < 27; k++) begin
            waitValid("t3_hdr0");
            tag = tlp_data[47:40];
            checkOutput("t3_rr_chan", 64'(tag >> 3), 64'(seqCh[k % 3]));
            @(negedge clock);
            if (seqCh[k % 3] == 3) begin
                checkOutput("t3_ch3_tag", 64'(tag), 64'(8'h18 + 8'(n3 % 8)));
                checkOutput("t3_ch3_addr", tlp_data, hdr1Lo(32'h0004_0000 + 32'(n3 * 32'h200)));
                n3++;
            end
        end
        applyStimulus(1);
        req_valid = '0;
        applyStimulus(2);

        // Backpressure: beats held, strobe only after HDR1 accepted
        tlp_ready = 1'b0;
        writeAddr(6, 64'h0000_0000_00AB_C000);
        req_valid = 8'h40;
        waitValid("t4_hdr0");
        held = tlp_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("t4_hold_hdr0", tlp_data, held);
            checkOutput("t4_hold_last", 64'(tlp_last), 64'd0);
            checkOutput("t4_hold_ready", 64'(req_ready), 64'd0);
        end
        applyStimulus(1);
        tlp_ready = 1'b1;
        req_valid = '0;
        applyStimulus(1);
        tlp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("t4_hold_hdr1", tlp_data, hdr1Lo(32'h00AB_C000));
            checkOutput("t4_hold_ready1", 64'(req_ready), 64'd0);
        end
        applyStimulus(1);
        tlp_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checkOutput("t4_ready_pulse", 64'(req_ready), 64'h40);
        applyStimulus(1);

        // Address write coinciding with the increment on channel 4
        writeAddr(4, 64'h0000_0000_0010_0000);
        req_valid = 8'h10;
        waitValid("t5_first");
        applyStimulus(1);
        addr_write   = 1'b1;
        addr_channel = 3'd4;
        addr_data    = 64'h0000_0000_0077_7000;
        applyStimulus(1);
        addr_write = 1'b0;
        waitValid("t5_second");
        checkOutput("t5_tag", 64'(tlp_data[47:40]), 64'h21);
        @(negedge clock);
        checkOutput("t5_written_addr", tlp_data, hdr1Lo(32'h0077_7000));
        applyStimulus(1);
        req_valid = '0;
        applyStimulus(2);

        // Reset during a stalled HDR1
        req_valid = 8'h01;
        waitValid("t6_hdr0");
        applyStimulus(1);
        tlp_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        applyStimulus(1);
        reset     = 1'b0;
        tlp_ready = 1'b1;
        @(negedge clock);
        checkOutput("t6_valid_after_reset", 64'(tlp_valid), 64'd0);
        checkOutput("t6_no_ready", 64'(req_ready), 64'd0);
        waitValid("t6_regrant");
        checkOutput("t6_tag_reset", 64'(tlp_data[47:40]), 64'h00);
        applyStimulus(1);
        req_valid = '0;
        applyStimulus(3);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            reset        = ($urandom_range(0, 249) == 0);
            req_valid    = NCH'($urandom);
            chan_enable  = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
            tlp_ready    = ($urandom_range(0, 3) != 0);
            addr_write   = ($urandom_range(0, 5) == 0);
            addr_channel = 3'($urandom);
            addr_data    = $urandom_range(0, 1) ? {32'h0, 32'($urandom)} : {32'($urandom), 32'($urandom)};
            applyStimulus(1);
        end
        reset      = 1'b0;
        req_valid  = '0;
        addr_write = 1'b0;
        tlp_ready  = 1'b1;
        applyStimulus(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
